pkt_tx_framer: RTL and testbench

Transmit-side packet framer for the EER-RL node. Builds heartbeat relays, cluster-head election (CHE) announcements, timeslot assignments, data packets and SOS packets from node state and per-request fields. Serializes each packet as 16-bit words on a valid/ready stream toward the radio/MAC. Member nodes can be held to their assigned TDMA slot before data packets are sent.

---
 rtl/pkt_tx_framer.sv | 202 ++++++++++++++++++++
 tb/tb_pkt_tx_framer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_framer.sv
// Transmit-side packet framer: builds HB/CHE/TS/DATA/SOS packets and streams them as 16-bit words.
// Optional build macro SLOT_GATE_EN holds member DATA packets until their TDMA slot.
module pkt_tx_framer #(
  parameter logic [15:0] BCAST_ID = 16'hFFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        tx_req,
  input  logic [2:0]  tx_type,
  input  logic [15:0] tx_dest,
  input  logic [15:0] tx_payload,
  output logic        tx_ack,
  input  logic [15:0] myNodeID,
  input  logic [15:0] hopsFromSink,
  input  logic [15:0] myQValue,
  input  logic [15:0] timeslot,
  input  logic        role,
  input  logic        low_E,
  input  logic        frame_start,
  input  logic        slot_tick,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_drop
);

  localparam logic [2:0] TYPE_HB   = 3'b000;
  localparam logic [2:0] TYPE_CHE  = 3'b001;
  localparam logic [2:0] TYPE_TS   = 3'b100;
  localparam logic [2:0] TYPE_DATA = 3'b101;
  localparam logic [2:0] TYPE_SOS  = 3'b110;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
`ifdef SLOT_GATE_EN
  localparam logic [1:0] ST_WAIT_SLOT = 2'd2;
`endif

  logic [1:0]  state;
  logic [2:0]  word_idx;
  logic [2:0]  last_idx;
  logic [15:0] pkt_word [8];

  logic        type_valid;
  logic        req_drop;
  logic        accept_ok;
  logic [7:0]  req_len;
  logic [15:0] hops_inc;
  logic [15:0] req_word [8];
  logic        gate_req;
  logic        slot_hit;

  // Request decode: the full packet image is assembled here so that acceptance
  // is a single snapshot of every field the packet uses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    for (int i = 0; i < 8; i++) req_word[i] = '0;
    type_valid  = 1'b1;
    req_len     = 8'd0;
    hops_inc    = (hopsFromSink == 16'hFFFF) ? 16'hFFFF : hopsFromSink + 16'd1;
    req_word[1] = myNodeID;
    case (tx_type)
      TYPE_HB: begin
        req_len     = 8'd5;
        req_word[2] = BCAST_ID;
        req_word[3] = hops_inc;
        req_word[4] = tx_payload;
      end
      TYPE_CHE: begin
        req_len     = 8'd5;
        req_word[2] = tx_dest;
        req_word[3] = hopsFromSink;
        req_word[4] = myQValue;
      end
      TYPE_TS: begin
        req_len     = 8'd5;
        req_word[2] = tx_dest;
        req_word[3] = hopsFromSink;
        req_word[4] = tx_payload;
      end
      TYPE_DATA: begin
        req_len     = 8'd6;
        req_word[2] = tx_dest;
        req_word[3] = hopsFromSink;
        req_word[4] = myQValue;
        req_word[5] = tx_payload;
      end
      TYPE_SOS: begin
        req_len     = 8'd3;
        req_word[2] = BCAST_ID;
      end
      default: type_valid = 1'b0;
    endcase
    req_word[0] = {tx_type, 5'b0, req_len};
    req_drop    = !type_valid || (tx_type == TYPE_HB && low_E);
  end

  assign tx_ack    = tx_req && (state == ST_IDLE) && nrst;
  assign accept_ok = tx_ack && !req_drop;

`ifdef SLOT_GATE_EN
  logic [15:0] slot_cnt;
  logic [15:0] slot_q;

  // Slot counter runs in every state; a frame start overrides a coincident tick.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      slot_cnt <= '0;
    end else if (frame_start) begin
      slot_cnt <= '0;
    end else if (slot_tick && slot_cnt != 16'hFFFF) begin
      slot_cnt <= slot_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_ok) slot_q <= timeslot;
  end

  // A member whose slot is already current at acceptance goes straight to SEND.
  assign gate_req = (tx_type == TYPE_DATA) && !role && (slot_cnt != timeslot);
  assign slot_hit = (slot_cnt == slot_q);
`else
  logic unused_slot_inputs;

  assign gate_req           = 1'b0;
  assign slot_hit           = 1'b1;
  assign unused_slot_inputs = &{1'b0, frame_start, slot_tick, role, timeslot};
`endif

  // NOTE: the packet image is pure datapath, only read while in SEND, so it is
  // loaded on acceptance and deliberately carries no reset.
  always_ff @(posedge clk) begin
    if (accept_ok) begin
      for (int i = 0; i < 8; i++) pkt_word[i] <= req_word[i];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!nrst) begin
      state    <= ST_IDLE;
      word_idx <= '0;
      last_idx <= '0;
      tx_done  <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_ack) begin
            if (req_drop) begin
              tx_drop <= 1'b1;
            end else begin
              word_idx <= '0;
              last_idx <= req_len[2:0] - 3'd1;
`ifdef SLOT_GATE_EN
              state    <= gate_req ? ST_WAIT_SLOT : ST_SEND;
`else
              state    <= ST_SEND;
`endif
            end
          end
        end
`ifdef SLOT_GATE_EN
        ST_WAIT_SLOT: begin
          if (slot_hit) state <= ST_SEND;
        end
`endif
        ST_SEND: begin
          if (tx_ready) begin
            if (word_idx == last_idx) begin
              state   <= ST_IDLE;
              tx_done <= 1'b1;
            end else begin
              word_idx <= word_idx + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SLOT_GATE_EN
  logic unused_gate;
  assign unused_gate = &{1'b0, gate_req, slot_hit};
`endif

  // Stream outputs derive from registered state, so they hold while stalled.
  assign tx_valid = (state == ST_SEND);
  assign tx_data  = tx_valid ? pkt_word[word_idx] : '0;
  assign tx_last  = tx_valid && (word_idx == last_idx);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pkt_tx_framer.sv
// Scoreboard bench for pkt_tx_framer: directed cases plus randomized requests checked
// against a field-list reference model; a separate monitor compares streamed words.
module tb_pkt_tx_framer;

  localparam logic [15:0] BCAST = 16'hFFFF;

  logic        clk = 1'b0;
  logic        nrst;
  logic        tx_req;
  logic [2:0]  tx_type;
  logic [15:0] tx_dest;
  logic [15:0] tx_payload;
  logic        tx_ack;
  logic [15:0] myNodeID;
  logic [15:0] hopsFromSink;
  logic [15:0] myQValue;
  logic [15:0] timeslot;
  logic        role;
  logic        low_E;
  logic        frame_start;
  logic        slot_tick;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        tx_done;
  logic        tx_drop;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ready_mode = 0;
`ifdef SLOT_GATE_EN
  logic [15:0] slot_model = 16'd0;
`endif

  pkt_tx_framer #(.BCAST_ID(BCAST)) dut (
    .clk(clk), .nrst(nrst),
    .tx_req(tx_req), .tx_type(tx_type), .tx_dest(tx_dest), .tx_payload(tx_payload),
    .tx_ack(tx_ack),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .timeslot(timeslot), .role(role), .low_E(low_E),
    .frame_start(frame_start), .slot_tick(slot_tick),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .tx_done(tx_done), .tx_drop(tx_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: the packet is a header plus a list of fields; length is the
  // number of words in the list plus one for the header.
  task automatic model_push(input logic [2:0] t, input logic [15:0] dst, pl, id, hops, q,
                            input logic le, output bit drop);
    logic [15:0] body [$];
    logic [15:0] hops_p1;
    drop    = 1'b0;
    hops_p1 = (32'(hops) + 1 > 32'hFFFF) ? 16'hFFFF : hops + 16'd1;
    body.push_back(id);
    case (t)
      3'b000: begin
        if (le) drop = 1'b1;
        body.push_back(BCAST); body.push_back(hops_p1); body.push_back(pl);
      end
      3'b001: begin body.push_back(dst); body.push_back(hops); body.push_back(q); end
      3'b100: begin body.push_back(dst); body.push_back(hops); body.push_back(pl); end
      3'b101: begin
        body.push_back(dst); body.push_back(hops); body.push_back(q); body.push_back(pl);
      end
      3'b110: body.push_back(BCAST);
      default: drop = 1'b1;
    endcase
    if (!drop) begin
      exp_q.push_back('{data: {t, 5'b0, 8'(body.size() + 1)}, last: 1'b0});
      foreach (body[i]) exp_q.push_back('{data: body[i], last: (i == body.size() - 1)});
    end
  endtask

  task automatic send_req(input logic [2:0] t, input logic [15:0] dst, pl, id, hops, q, ts,
                          input logic rl, le);
    bit drop, gated, was_busy, acked;
    @(posedge clk); #1;
    tx_type = t; tx_dest = dst; tx_payload = pl; myNodeID = id; hopsFromSink = hops;
    myQValue = q; timeslot = ts; role = rl; low_E = le; tx_req = 1'b1;
    was_busy = 1'b0;
    acked    = 1'b0;
    for (int i = 0; i < 300 && !acked; i++) begin
      @(negedge clk);
      if (tx_ack) acked = 1'b1;
      else was_busy = 1'b1;
    end
    if (!acked) begin
      check(1'b0, "ack_timeout", 32'(tx_ack), 32'd1);
      tx_req = 1'b0;
      return;
    end
    if (was_busy) check(tx_done === 1'b1, "ack_on_done_cycle", 32'(tx_done), 32'd1);
    model_push(t, dst, pl, id, hops, q, le, drop);
`ifdef SLOT_GATE_EN
    gated = !drop && t == 3'b101 && !rl && ts != slot_model;
`else
    gated = 1'b0;
`endif
    @(posedge clk); #1;
    tx_req = 1'b0;
    tx_type = 3'($urandom); tx_dest = 16'($urandom); tx_payload = 16'($urandom);
    myNodeID = 16'($urandom); hopsFromSink = 16'($urandom); myQValue = 16'($urandom);
    timeslot = 16'($urandom); role = 1'($urandom); low_E = 1'($urandom);
    @(negedge clk);
    if (drop)
      check(tx_drop && !tx_valid && !busy, "drop_pulse", 32'({tx_drop, tx_valid, busy}),
            32'b100);
    else if (gated)
      check(!tx_valid && busy && !tx_drop, "gate_hold", 32'({tx_drop, tx_valid, busy}),
            32'b001);
    else
      check(tx_valid && busy && !tx_drop, "first_word_latency",
            32'({tx_drop, tx_valid, busy}), 32'b011);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && exp_q.size() == 0;
    end
    if (!idle) check(1'b0, "idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability and
  // the tx_done pulse following the final word.
  initial begin
    exp_t        e;
    bit          stalled;
    bit          done_exp;
    logic [15:0] held;
    logic        held_last;
    stalled  = 1'b0;
    done_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (done_exp || tx_done)
        check(tx_done === done_exp && !(done_exp && busy), "done_pulse",
              32'({tx_done, busy}), 32'({done_exp, 1'b0}));
      done_exp = 1'b0;
      if (stalled)
        check(tx_valid && tx_data === held && tx_last === held_last, "stall_hold",
              32'({tx_valid, tx_last, tx_data}), 32'({1'b1, held_last, held}));
      stalled = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", 32'(tx_data), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(tx_data === e.data && tx_last === e.last, "word",
                32'({tx_last, tx_data}), 32'({e.last, e.data}));
          done_exp = e.last && nrst;
        end
      end else if (tx_valid) begin
        stalled   = nrst;
        held      = tx_data;
        held_last = tx_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  t;
    logic [15:0] hops, ts;
    logic        rl;
    nrst = 1'b0; tx_req = 1'b1; tx_type = 3'b000; tx_dest = '0; tx_payload = '0;
    myNodeID = '0; hopsFromSink = '0; myQValue = '0; timeslot = '0; role = 1'b1;
    low_E = 1'b0; frame_start = 1'b0; slot_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(!tx_ack, "ack_in_reset", 32'(tx_ack), 32'd0);
    check({tx_data, tx_valid, tx_last, busy, tx_done, tx_drop} == '0, "reset_outputs",
          32'({tx_valid, tx_last, busy, tx_done, tx_drop}), 32'd0);
    @(posedge clk); #1;
    tx_req = 1'b0; nrst = 1'b1;

    // Heartbeat relay, ready held high.
    ready_mode = 0;
    send_req(3'b000, 16'h0000, 16'h0050, 16'h000C, 16'h0003, 16'h0000, 16'h0, 1'b1, 1'b0);
    wait_idle();

    // Cluster-head DATA with a stalling sink.
    ready_mode = 1;
    send_req(3'b101, 16'h0001, 16'hABCD, 16'h000C, 16'h0003, 16'h1234, 16'h0, 1'b1, 1'b0);
    wait_idle();
    ready_mode = 0;

    // Drops: low-energy heartbeat and undefined type.
    send_req(3'b000, 16'h0000, 16'h0050, 16'h000C, 16'h0003, 16'h0000, 16'h0, 1'b1, 1'b1);
    send_req(3'b011, 16'h0002, 16'h0050, 16'h000C, 16'h0003, 16'h0000, 16'h0, 1'b1, 1'b0);
    wait_idle();

    // Saturating hop count.
    send_req(3'b000, 16'h0000, 16'h0077, 16'h000C, 16'hFFFF, 16'h0000, 16'h0, 1'b1, 1'b0);
    wait_idle();

    // Reset during W2 aborts the packet.
    send_req(3'b000, 16'h0000, 16'h0050, 16'h000C, 16'h0003, 16'h0000, 16'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tx_data, tx_valid, tx_last, busy, tx_done, tx_drop} == '0, "mid_packet_reset",
          32'({tx_valid, tx_last, busy, tx_done, tx_drop}), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    nrst = 1'b1;

`ifdef SLOT_GATE_EN
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
    slot_model = 16'd0;
    send_req(3'b101, 16'h0001, 16'h5A5A, 16'h000C, 16'h0003, 16'h1234, 16'd2, 1'b0, 1'b0);
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0; slot_tick = 1'b1;
    @(posedge clk); #1; slot_tick = 1'b0;
    @(posedge clk); #1; slot_tick = 1'b1;
    @(posedge clk); #1; slot_tick = 1'b0;
    @(negedge clk);
    check(!tx_valid, "gate_not_early", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check(tx_valid, "gate_rise", 32'(tx_valid), 32'd1);
    slot_model = 16'd2;
    wait_idle();
`endif

    // Randomized traffic, half of it back-to-back.
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      t    = 3'($urandom);
      rl   = 1'($urandom);
      hops = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      ts   = 16'($urandom);
`ifdef SLOT_GATE_EN
      if (!rl) ts = slot_model;
`endif
      send_req(t, 16'($urandom), 16'($urandom), 16'($urandom), hops, 16'($urandom), ts, rl,
               1'($urandom_range(0, 3) == 0));
      if (k % 2 == 0) wait_idle();
    end
    wait_idle();
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
